// File: rtl/seq_detector_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_detector_if
// Description : Symbol-stream and configuration bundle for seq_detector.
//               master : symbol source / configuring agent
//               slave  : the detector
//               Signals: in_valid, in_sym, overlap, cfg_load, cfg_pattern,
//               cnt_clr (to detector); match, match_cnt (from detector).
//               match_cnt exists only when SEQDET_COUNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_detector_if #(
  parameter int unsigned SYM_W   = 1,
  parameter int unsigned PAT_LEN = 3,
  parameter int unsigned CNT_W   = 8
);
  logic                     in_valid;
  logic [SYM_W-1:0]         in_sym;
  logic                     overlap;
  logic                     cfg_load;
  logic [PAT_LEN*SYM_W-1:0] cfg_pattern;
  logic                     cnt_clr;
  logic                     match;

`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0]         match_cnt;

  modport master (
    output in_valid, in_sym, overlap, cfg_load, cfg_pattern, cnt_clr,
    input  match, match_cnt
  );
  modport slave (
    input  in_valid, in_sym, overlap, cfg_load, cfg_pattern, cnt_clr,
    output match, match_cnt
  );
`else
  localparam int unsigned c_cnt_w_unused = CNT_W;

  modport master (
    output in_valid, in_sym, overlap, cfg_load, cfg_pattern, cnt_clr,
    input  match
  );
  modport slave (
    input  in_valid, in_sym, overlap, cfg_load, cfg_pattern, cnt_clr,
    output match
  );
`endif
endinterface
`default_nettype wire

// File: rtl/seq_detector.sv
`default_nettype none
// ============================================================================
// Module      : seq_detector
// Description : Runtime-programmable symbol-sequence detector. Emits a
//               one-cycle registered pulse on match each time the programmed
//               pattern completes in the accepted symbol stream, with
//               selectable overlapping / non-overlapping match mode.
//               Ports : clk, reset_n (async, active-low),
//                       bus (seq_detector_if.slave) carrying the symbol
//                       stream, configuration and match outputs.
//               Macro : SEQDET_COUNT_EN enables the saturating match counter
//                       (match_cnt) and its synchronous clear (cnt_clr).
// Revision    : 1.0 - initial release
// ============================================================================
module seq_detector #(
  parameter int unsigned                 SYM_W     = 1,
  parameter int unsigned                 PAT_LEN   = 3,
  parameter logic [PAT_LEN*SYM_W-1:0]    PAT_RESET = '0,
  parameter int unsigned                 CNT_W     = 8
) (
  input  wire logic     clk,
  input  wire logic     reset_n,
  seq_detector_if.slave bus
);

  localparam int unsigned           c_HIST_W    = PAT_LEN * SYM_W;
  localparam int unsigned           c_FILL_W    = $clog2(PAT_LEN + 1);
  localparam logic [c_FILL_W-1:0]   c_FILL_FULL = c_FILL_W'(PAT_LEN);
  localparam logic [c_FILL_W-1:0]   c_FILL_ONE  = c_FILL_W'(1);

  // HUNT: fewer than PAT_LEN symbols collected; ARMED: history is full.
  typedef enum logic [0:0] {
    HUNT  = 1'b0,
    ARMED = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [c_HIST_W-1:0]   r_pat;
  logic [c_HIST_W-1:0]   r_hist;
  logic [c_HIST_W-1:0]   w_hist_nxt;
  logic [c_HIST_W-1:0]   w_hist_sh;
  logic [c_FILL_W-1:0]   r_fill;
  logic [c_FILL_W-1:0]   w_fill_nxt;
  logic [c_FILL_W-1:0]   w_fill_inc;
  logic                  w_full;
  logic                  r_match;
  logic                  w_match_nxt;

  // Newest symbol enters the low bits; oldest falls off the top, so a
  // complete history lines up with the pattern's first-symbol-on-top layout.
  assign w_hist_sh  = {r_hist[c_HIST_W-SYM_W-1:0], bus.in_sym};
  assign w_fill_inc = (r_fill == c_FILL_FULL) ? r_fill : r_fill + c_FILL_ONE;
  assign w_full     = (w_fill_inc == c_FILL_FULL);

  always_comb begin
    w_state_nxt = r_state;
    w_hist_nxt  = r_hist;
    w_fill_nxt  = r_fill;
    w_match_nxt = 1'b0;

    if (bus.cfg_load) begin
      // A symbol presented alongside a load is dropped on purpose: it
      // belongs to neither the old nor the new pattern.
      w_fill_nxt  = '0;
      w_state_nxt = HUNT;
    end else if (bus.in_valid) begin
      w_hist_nxt  = w_hist_sh;
      w_fill_nxt  = w_fill_inc;
      w_state_nxt = w_full ? ARMED : HUNT;
      if (w_full && (w_hist_sh == r_pat)) begin
        w_match_nxt = 1'b1;
        // Non-overlapping: forget the matched symbols so the next match
        // needs a full fresh pattern. History content is left as is; the
        // fill count alone gates matching.
        if (!bus.overlap) begin
          w_fill_nxt  = '0;
          w_state_nxt = HUNT;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= HUNT;
      r_pat   <= PAT_RESET;
      r_hist  <= '0;
      r_fill  <= '0;
      r_match <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hist  <= w_hist_nxt;
      r_fill  <= w_fill_nxt;
      r_match <= w_match_nxt;
      if (bus.cfg_load) begin
        r_pat <= bus.cfg_pattern;
      end
    end
  end

  assign bus.match = r_match;

`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0] r_cnt;

  // Clear has priority over a coincident match increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (bus.cnt_clr) begin
      r_cnt <= '0;
    end else if (w_match_nxt && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.match_cnt = r_cnt;
`else
  localparam int unsigned c_cnt_w_unused = CNT_W;
  logic w_cnt_clr_unused;
  assign w_cnt_clr_unused = bus.cnt_clr;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_detector
// Description : Self-checking bench for seq_detector. Three instances:
//               u_a SYM_W=1 PAT_LEN=3 CNT_W=2 reset pattern 011
//               u_b SYM_W=1 PAT_LEN=2          reset pattern 11
//               u_c SYM_W=4 PAT_LEN=3          reset pattern A,5,C
//               Expected match bits are queued as each symbol is driven and
//               popped after the following clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detector;

  logic clk;
  logic reset_n;

  int n_chk;
  int n_fail;

  bit exp_q[$];

  seq_detector_if #(.SYM_W(1), .PAT_LEN(3), .CNT_W(2)) bus_a ();
  seq_detector_if #(.SYM_W(1), .PAT_LEN(2), .CNT_W(8)) bus_b ();
  seq_detector_if #(.SYM_W(4), .PAT_LEN(3), .CNT_W(8)) bus_c ();

  seq_detector #(.SYM_W(1), .PAT_LEN(3), .PAT_RESET(3'b011), .CNT_W(2)) u_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a));
  seq_detector #(.SYM_W(1), .PAT_LEN(2), .PAT_RESET(2'b11), .CNT_W(8)) u_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b));
  seq_detector #(.SYM_W(4), .PAT_LEN(3), .PAT_RESET(12'hA5C), .CNT_W(8)) u_c (
    .clk(clk), .reset_n(reset_n), .bus(bus_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of stimulus, queue the expected match, advance past edge.
  task automatic cyc_a(input bit v, input bit s, input bit m);
    bus_a.in_valid = v;
    bus_a.in_sym   = s;
    exp_q.push_back(m);
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_b(input bit v, input bit s, input bit m);
    bus_b.in_valid = v;
    bus_b.in_sym   = s;
    exp_q.push_back(m);
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_c(input bit v, input logic [3:0] s, input bit m);
    bus_c.in_valid = v;
    bus_c.in_sym   = s;
    exp_q.push_back(m);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if ({bus_a.match, bus_b.match, bus_c.match} !== 3'b000) begin
      $display("FAIL reset_match: got %b required 000",
               {bus_a.match, bus_b.match, bus_c.match});
      n_fail++;
    end
`ifdef SEQDET_COUNT_EN
    n_chk++;
    if (bus_a.match_cnt !== 2'd0) begin
      $display("FAIL reset_cnt: got %0d required 0", bus_a.match_cnt);
      n_fail++;
    end
`endif
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    bit s[3] = '{1'b0, 1'b1, 1'b1};
    bit m[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    bit e;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) cyc_a(1'b1, s[i], m[i]);
      else       cyc_a(1'b0, 1'b0, m[i]);
      e = exp_q.pop_front();
      n_chk++;
      if (bus_a.match !== e) begin
        $display("FAIL basic_match[%0d]: got %b required %b", i, bus_a.match, e);
        n_fail++;
      end
    end
`ifdef SEQDET_COUNT_EN
    n_chk++;
    if (bus_a.match_cnt !== 2'd1) begin
      $display("FAIL basic_cnt: got %0d required 1", bus_a.match_cnt);
      n_fail++;
    end
`endif
  endtask

  task automatic test_overlap();
    bit m1[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    bit m0[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    bit e;
    bus_b.overlap = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc_b(i < 4, 1'b1, m1[i]);
      e = exp_q.pop_front();
      n_chk++;
      if (bus_b.match !== e) begin
        $display("FAIL overlap1[%0d]: got %b required %b", i, bus_b.match, e);
        n_fail++;
      end
    end
    // Reload the same pattern to restart from an empty history.
    bus_b.cfg_load    = 1'b1;
    bus_b.cfg_pattern = 2'b11;
    cyc_b(1'b0, 1'b0, 1'b0);
    bus_b.cfg_load    = 1'b0;
    e = exp_q.pop_front();
    n_chk++;
    if (bus_b.match !== e) begin
      $display("FAIL overlap_load: got %b required %b", bus_b.match, e);
      n_fail++;
    end
    bus_b.overlap = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc_b(1'b1, 1'b1, m0[i]);
      e = exp_q.pop_front();
      n_chk++;
      if (bus_b.match !== e) begin
        $display("FAIL overlap0[%0d]: got %b required %b", i, bus_b.match, e);
        n_fail++;
      end
    end
    cyc_b(1'b0, 1'b0, 1'b0);
    void'(exp_q.pop_front());
  endtask

  task automatic test_gapped();
    bit         v[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0] s[7] = '{4'hA, 4'hF, 4'h5, 4'hC, 4'hA, 4'hC, 4'h0};
    bit         m[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    bit e;
    for (int i = 0; i < 7; i++) begin
      cyc_c(v[i], s[i], m[i]);
      e = exp_q.pop_front();
      n_chk++;
      if (bus_c.match !== e) begin
        $display("FAIL gapped[%0d]: got %b required %b", i, bus_c.match, e);
        n_fail++;
      end
    end
  endtask

  task automatic test_cfg_load();
    bit s[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    bit m[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    bit e;
    bus_a.overlap = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus_a.cfg_load    = (i == 2);
      bus_a.cfg_pattern = 3'b110;
      cyc_a(1'b1, s[i], m[i]);
      e = exp_q.pop_front();
      n_chk++;
      if (bus_a.match !== e) begin
        $display("FAIL cfg_load[%0d]: got %b required %b", i, bus_a.match, e);
        n_fail++;
      end
    end
    bus_a.cfg_load = 1'b0;
  endtask

  task automatic test_saturation();
    bit e;
    bus_a.cnt_clr = 1'b1;
    cyc_a(1'b0, 1'b0, 1'b0);
    bus_a.cnt_clr = 1'b0;
    void'(exp_q.pop_front());
`ifdef SEQDET_COUNT_EN
    n_chk++;
    if (bus_a.match_cnt !== 2'd0) begin
      $display("FAIL sat_clr: got %0d required 0", bus_a.match_cnt);
      n_fail++;
    end
`endif
    for (int k = 1; k <= 6; k++) begin
      cyc_a(1'b1, 1'b1, 1'b0);
      cyc_a(1'b1, 1'b1, 1'b0);
      if (k == 6) bus_a.cnt_clr = 1'b1;
      cyc_a(1'b1, 1'b0, 1'b1);
      bus_a.cnt_clr = 1'b0;
      for (int j = 0; j < 3; j++) begin
        e = exp_q.pop_front();
        if (j == 2) begin
          n_chk++;
          if (bus_a.match !== e) begin
            $display("FAIL sat_match[%0d]: got %b required %b", k, bus_a.match, e);
            n_fail++;
          end
        end
      end
`ifdef SEQDET_COUNT_EN
      n_chk++;
      if (bus_a.match_cnt !== ((k == 6) ? 2'd0 : ((k > 3) ? 2'd3 : 2'(k)))) begin
        $display("FAIL sat_cnt[%0d]: got %0d required %0d", k, bus_a.match_cnt,
                 (k == 6) ? 0 : ((k > 3) ? 3 : k));
        n_fail++;
      end
`endif
    end
  endtask

  task automatic test_reset_mid();
    bit s[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    bit m[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    bit e;
    // Pattern is still 110 here: produce a live pulse, then reset under it.
    cyc_a(1'b1, 1'b1, 1'b0);
    cyc_a(1'b1, 1'b1, 1'b0);
    cyc_a(1'b1, 1'b0, 1'b1);
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    e = exp_q.pop_front();
    n_chk++;
    if (bus_a.match !== e) begin
      $display("FAIL rstmid_pre: got %b required %b", bus_a.match, e);
      n_fail++;
    end
    #2 reset_n = 1'b0;
    #1;
    n_chk++;
    if (bus_a.match !== 1'b0) begin
      $display("FAIL rstmid_async_match: got %b required 0", bus_a.match);
      n_fail++;
    end
`ifdef SEQDET_COUNT_EN
    n_chk++;
    if (bus_a.match_cnt !== 2'd0) begin
      $display("FAIL rstmid_async_cnt: got %0d required 0", bus_a.match_cnt);
      n_fail++;
    end
`endif
    @(posedge clk);
    #1 reset_n = 1'b1;
    // Reset restored pattern 011: accept 0,1 then reset before the final 1.
    cyc_a(1'b1, 1'b0, 1'b0);
    cyc_a(1'b1, 1'b1, 1'b0);
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    reset_n = 1'b0;
    #1 reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc_a(1'b1, s[i], m[i]);
      e = exp_q.pop_front();
      n_chk++;
      if (bus_a.match !== e) begin
        $display("FAIL rstmid[%0d]: got %b required %b", i, bus_a.match, e);
        n_fail++;
      end
    end
    cyc_a(1'b0, 1'b0, 1'b0);
    void'(exp_q.pop_front());
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset_n = 1'b0;
    bus_a.in_valid = 1'b0; bus_a.in_sym = '0; bus_a.overlap = 1'b0;
    bus_a.cfg_load = 1'b0; bus_a.cfg_pattern = '0; bus_a.cnt_clr = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_sym = '0; bus_b.overlap = 1'b0;
    bus_b.cfg_load = 1'b0; bus_b.cfg_pattern = '0; bus_b.cnt_clr = 1'b0;
    bus_c.in_valid = 1'b0; bus_c.in_sym = '0; bus_c.overlap = 1'b0;
    bus_c.cfg_load = 1'b0; bus_c.cfg_pattern = '0; bus_c.cnt_clr = 1'b0;

    test_reset();
    test_basic();
    test_overlap();
    test_gapped();
    test_cfg_load();
    test_saturation();
    test_reset_mid();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
